// File: rtl/pe_result_drain.sv
// ---------------------------------------------------------------------------
// pe_result_drain
//
// Purpose:
//   Output stage of the PE array. Each packed result vector (one byte per PE)
//   is stored in a small first-word-fall-through FIFO. The head vector is then
//   sent out one lane at a time as a byte stream with a valid/ready handshake.
//   This lets the array keep its fixed result rate while the consumer applies
//   back-pressure. If a vector arrives while the FIFO is full and nothing is
//   leaving, the vector is dropped and a sticky overflow flag is set.
//
// Ports:
//   iClk            clock; all state changes on the rising edge
//   iRstN           asynchronous active-low reset
//   iResultValid    iResult carries a new vector this cycle
//   iResult         packed vector; lane k is bits [8k+7:8k]
//   iFlush          synchronous clear of FIFO contents and lane pointer
//   iClearOverflow  synchronous clear of oOverflow
//   iReady          consumer accepts oData this cycle
//   oData           current lane byte of the head vector (0 when empty)
//   oValid          oData is valid (FIFO not empty)
//   oLast           oData is the last lane of its vector
//   oFull           FIFO holds FIFO_DEPTH vectors
//   oCount          number of vectors currently stored
//   oOverflow       sticky flag: at least one vector was dropped
// ---------------------------------------------------------------------------
module pe_result_drain #(
  parameter int ARRAY_NUM  = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             iClk,
  input  logic                             iRstN,
  input  logic                             iResultValid,
  input  logic [8*ARRAY_NUM-1:0]           iResult,
  input  logic                             iFlush,
  input  logic                             iClearOverflow,
  input  logic                             iReady,
  output logic [7:0]                       oData,
  output logic                             oValid,
  output logic                             oLast,
  output logic                             oFull,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  oCount,
  output logic                             oOverflow
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int LANE_W = $clog2(ARRAY_NUM);

  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(ARRAY_NUM - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // Vector storage. It has no reset: an entry is only ever read after it
  // has been written, because count_reg guards every read.
  logic [8*ARRAY_NUM-1:0] mem_reg [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg,   wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg,   rd_ptr_next;
  logic [LANE_W-1:0] lane_idx_reg, lane_idx_next;
  logic [CNT_W-1:0]  count_reg,    count_next;
  logic              overflow_reg, overflow_next;

  logic                   not_empty;
  logic                   full;
  logic                   transfer;
  logic                   pop;
  logic                   wr_en;
  logic                   drop;
  logic [8*ARRAY_NUM-1:0] head_word;
  logic [7:0]             head_lane [ARRAY_NUM];

  // Status decode. This uses registered state only, so oValid does not
  // depend on iReady.
  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == FULL_COUNT);

  // A transfer on the last lane retires the head vector. A write is
  // accepted when the FIFO is full only if the head leaves in the same
  // cycle. A flush cancels both the write and the transfer.
  assign transfer = not_empty && iReady;
  assign pop      = transfer && (lane_idx_reg == LAST_LANE);
  assign wr_en    = iResultValid && (!full || pop) && !iFlush;
  assign drop     = iResultValid && full && !pop;

  // Split the head vector into byte lanes, then pick the active lane.
  assign head_word = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < ARRAY_NUM; gi++) begin : g_lane
      assign head_lane[gi] = head_word[8*gi +: 8];
    end
  endgenerate

  assign oData     = not_empty ? head_lane[lane_idx_reg] : 8'h00;
  assign oValid    = not_empty;
  assign oLast     = not_empty && (lane_idx_reg == LAST_LANE);
  assign oFull     = full;
  assign oCount    = count_reg;
  assign oOverflow = overflow_reg;

  // Next-state logic
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    lane_idx_next = lane_idx_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    if (iFlush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      lane_idx_next = '0;
      count_next    = '0;
    end else begin
      if (transfer) begin
        if (pop) begin
          lane_idx_next = '0;
          // Power-of-two depth: the pointer wraps by natural rollover.
          rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
        end else begin
          lane_idx_next = lane_idx_reg + LANE_W'(1);
        end
      end
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      // A write and a pop in the same cycle leave the count unchanged.
      if (wr_en && !pop) begin
        count_next = count_reg + CNT_W'(1);
      end else if (pop && !wr_en) begin
        count_next = count_reg - CNT_W'(1);
      end
    end

    // If a drop and a clear request happen in the same cycle, the drop wins
    // so the lost vector is still reported.
    if (drop) begin
      overflow_next = 1'b1;
    end else if (iClearOverflow) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      lane_idx_reg <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      lane_idx_reg <= lane_idx_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_ff @(posedge iClk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= iResult;
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;

  localparam int AN = 3;
  localparam int FD = 4;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic [23:0] res;
  logic        flush;
  logic        clr_ovf;
  logic        ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_last;
  logic        o_full;
  logic [2:0]  o_count;
  logic        o_ovf;

  int total = 0;
  int bad   = 0;

  pe_result_drain #(.ARRAY_NUM(AN), .FIFO_DEPTH(FD)) dut (
    .iClk(clk), .iRstN(rst_n), .iResultValid(res_valid), .iResult(res),
    .iFlush(flush), .iClearOverflow(clr_ovf), .iReady(ready),
    .oData(o_data), .oValid(o_valid), .oLast(o_last), .oFull(o_full),
    .oCount(o_count), .oOverflow(o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Table of per-cycle stimulus, with the outputs expected after the edge.
  typedef struct {
    logic        v;
    logic [23:0] r;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic [2:0]  ec;
  } row_t;

  row_t tbl [10];

  // Scoreboard model. Expected bytes are queued when the bench drives a
  // write that must be accepted, and popped when a transfer occurs.
  logic [7:0] sb [$];
  int         m_count = 0;
  int         m_lane  = 0;
  logic       m_ovf   = 1'b0;

  task automatic drive(input logic v, input logic [23:0] r, input logic rdy,
                       input logic fl, input logic co);
    res_valid = v; res = r; ready = rdy; flush = fl; clr_ovf = co;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_cycle(input logic v, input logic [23:0] r, input logic rdy,
                          input logic fl, input logic co);
    logic xfer, pop_now, acc;
    // Check the outputs for the current state before this edge.
    chk("sb_valid", o_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("sb_data", o_data, sb[0]);
      chk("sb_last", o_last, m_lane == AN - 1);
    end
    chk("sb_count", o_count, m_count);
    chk("sb_full", o_full, m_count == FD);
    xfer    = (sb.size() != 0) && rdy;
    pop_now = xfer && (m_lane == AN - 1);
    acc     = v && ((m_count < FD) || pop_now);
    drive(v, r, rdy, fl, co);
    $display("cycle v=%0d r=%06h rdy=%0d fl=%0d xfer=%0d pop=%0d acc=%0d",
             v, r, rdy, fl, xfer, pop_now, acc);
    if (v && !acc) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
    if (fl) begin
      sb.delete();
      m_count = 0;
      m_lane  = 0;
    end else begin
      if (xfer) begin
        void'(sb.pop_front());
        if (pop_now) begin
          m_lane = 0;
          m_count--;
        end else begin
          m_lane++;
        end
      end
      if (acc) begin
        for (int k = 0; k < AN; k++) sb.push_back(r[8*k +: 8]);
        m_count++;
      end
    end
    chk("sb_ovf", o_ovf, m_ovf);
  endtask

  function automatic logic [23:0] vec(input int n);
    logic [7:0] b;
    b = 8'(n * 16);
    return {b + 8'd3, b + 8'd2, b + 8'd1};
  endfunction

  initial begin
    res_valid = 0; res = '0; flush = 0; clr_ovf = 0; ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_last",  o_last,  1'b0);
    chk("rst_full",  o_full,  1'b0);
    chk("rst_count", o_count, 3'd0);
    chk("rst_data",  o_data,  8'h00);
    chk("rst_ovf",   o_ovf,   1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single vector, then the back-pressure pattern 1,0,0,1,1.
    tbl[0] = '{1'b1, 24'h332211, 1'b1, 1'b1, 8'h11, 1'b0, 3'd1};
    tbl[1] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h22, 1'b0, 3'd1};
    tbl[2] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h33, 1'b1, 3'd1};
    tbl[3] = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    tbl[4] = '{1'b1, 24'h332211, 1'b0, 1'b1, 8'h11, 1'b0, 3'd1};
    tbl[5] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h22, 1'b0, 3'd1};
    tbl[6] = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h22, 1'b0, 3'd1};
    tbl[7] = '{1'b0, 24'h000000, 1'b0, 1'b1, 8'h22, 1'b0, 3'd1};
    tbl[8] = '{1'b0, 24'h000000, 1'b1, 1'b1, 8'h33, 1'b1, 3'd1};
    tbl[9] = '{1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].r, tbl[i].rdy, 1'b0, 1'b0);
      $display("row %0d: v=%0d rdy=%0d -> valid=%0d data=%02h last=%0d count=%0d",
               i, tbl[i].v, tbl[i].rdy, o_valid, o_data, o_last, o_count);
      chk($sformatf("row%0d_valid", i), o_valid, tbl[i].ev);
      chk($sformatf("row%0d_data", i),  o_data,  tbl[i].ed);
      chk($sformatf("row%0d_last", i),  o_last,  tbl[i].el);
      chk($sformatf("row%0d_count", i), o_count, tbl[i].ec);
      chk($sformatf("row%0d_ovf", i),   o_ovf,   1'b0);
    end

    // Fill and overflow: five writes with the consumer stalled.
    for (int i = 1; i <= 5; i++) sb_cycle(1'b1, vec(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full",  o_full,  1'b1);
    chk("fill_count", o_count, 3'd4);
    chk("fill_ovf",   o_ovf,   1'b1);
    for (int i = 0; i < 14; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fill_drained", sb.size(), 0);

    // Clear the overflow flag, then test a full FIFO with a pop and a write
    // in the same cycle.
    sb_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i <= 9; i++) sb_cycle(1'b1, vec(i), 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    sb_cycle(1'b1, vec(10), 1'b1, 1'b0, 1'b0);
    chk("fullpop_count", o_count, 3'd4);
    chk("fullpop_ovf",   o_ovf,   1'b0);
    for (int i = 0; i < 14; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fullpop_drained", sb.size(), 0);

    // Pointer wrap: ten vectors, one write every three cycles.
    for (int i = 0; i < 10; i++) begin
      sb_cycle(1'b1, vec(i + 3), 1'b1, 1'b0, 1'b0);
      chk("wrap_count_le1", o_count <= 3'd1, 1'b1);
      sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("wrap_drained", sb.size(), 0);

    // Flush after lane 0, with an overflow already recorded. The write and
    // transfer in the flush cycle must both be discarded.
    for (int i = 1; i <= 5; i++) sb_cycle(1'b1, vec(i), 1'b0, 1'b0, 1'b0);
    sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    sb_cycle(1'b1, vec(7), 1'b1, 1'b1, 1'b0);
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_count", o_count, 3'd0);
    chk("flush_ovf",   o_ovf,   1'b1);
    sb_cycle(1'b1, vec(8), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a vector.
    sb_cycle(1'b1, vec(9), 1'b1, 1'b0, 1'b0);
    sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    $display("async reset: valid=%0d data=%02h count=%0d ovf=%0d",
             o_valid, o_data, o_count, o_ovf);
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_data",  o_data,  8'h00);
    chk("arst_last",  o_last,  1'b0);
    chk("arst_count", o_count, 3'd0);
    chk("arst_ovf",   o_ovf,   1'b0);
    res_valid = 0; ready = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    m_count = 0;
    m_lane  = 0;
    m_ovf   = 1'b0;
    sb_cycle(1'b1, vec(11), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("arst_restart_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
